// File: rtl/raw8_frame_writer.sv
// raw8_frame_writer
// Crops packed RAW8 words (four pixels per word) from the unpacker to a fixed
// H_WORDS x V_LINES window. It produces word-wide writes into a two-bank frame
// buffer and swaps the banks on each complete frame, so the read side always
// sees the last complete frame.
//
// Ports
//   clk            pixel/byte clock
//   reset          synchronous, active-high
//   raw            four RAW8 pixels, pixel 0 in [7:0]
//   raw_enable     word valid; high for the whole payload of a line
//   frame_start    single-cycle frame-start marker
//   frame_end      single-cycle frame-end marker
//   wr_en          buffer write strobe, one cycle after the accepted word
//   wr_addr        word address including bank offset
//   wr_data        registered copy of raw
//   write_bank     bank currently being filled
//   read_bank      bank holding the last complete frame (~write_bank)
//   frame_done     one-cycle pulse when a frame completes and banks swap
//   dropped_frames saturating count of aborted or short frames
//
// state    | meaning
// S_IDLE   | between frames; words are ignored until frame_start
// S_ACTIVE | frame in progress; words inside the window are written

module raw8_frame_writer #(
   parameter int H_WORDS    = 160,
   parameter int V_LINES    = 480,
   parameter int ADDR_WIDTH = 18
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           raw,
   input  logic                  raw_enable,
   input  logic                  frame_start,
   input  logic                  frame_end,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [31:0]           wr_data,
   output logic                  write_bank,
   output logic                  read_bank,
   output logic                  frame_done,
   output logic [7:0]            dropped_frames
);

   localparam int X_W = $clog2(H_WORDS + 1);
   localparam int Y_W = $clog2(V_LINES + 1);
   localparam logic [X_W-1:0]        X_MAX      = X_W'(H_WORDS);
   localparam logic [Y_W-1:0]        Y_MAX      = Y_W'(V_LINES);
   localparam logic [ADDR_WIDTH-1:0] LINE_STEP  = ADDR_WIDTH'(H_WORDS);
   localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(H_WORDS * V_LINES);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t                state, state_n;
   logic [X_W-1:0]        x, x_n;
   logic [Y_W-1:0]        y, y_n;
   logic [ADDR_WIDTH-1:0] line_base, line_base_n;
   logic                  en_q;
   logic                  wr_en_n;
   logic [ADDR_WIDTH-1:0] wr_addr_n;
   logic [31:0]           wr_data_n;
   logic                  bank_n;
   logic                  done_n;
   logic                  drop_inc;
   logic                  restart;
   logic                  falling;
   logic [7:0]            dropped_n;

   always_comb begin
      state_n     = state;
      x_n         = x;
      y_n         = y;
      line_base_n = line_base;
      wr_en_n     = 1'b0;
      wr_addr_n   = wr_addr;
      wr_data_n   = wr_data;
      bank_n      = write_bank;
      done_n      = 1'b0;
      drop_inc    = 1'b0;
      restart     = 1'b0;
      falling     = en_q & ~raw_enable;

      case (state)
         S_IDLE: begin
            if (frame_start)
               restart = 1'b1;
         end
         S_ACTIVE: begin
            if (raw_enable && (x < X_MAX) && (y < Y_MAX)) begin
               wr_en_n   = 1'b1;
               wr_addr_n = line_base + ADDR_WIDTH'(x);
               wr_data_n = raw;
               x_n       = x + X_W'(1);
            end
            if (falling && (x != '0)) begin
               x_n         = '0;
               y_n         = y + Y_W'(1);
               line_base_n = line_base + LINE_STEP;
            end
            if (frame_end) begin
               // A line still open at frame_end (its last word coincides with
               // the marker) counts as finished; x is nonzero only while y < V_LINES.
               if ((y_n + Y_W'(x_n != '0)) >= Y_MAX) begin
                  bank_n = ~write_bank;
                  done_n = 1'b1;
               end else begin
                  drop_inc = 1'b1;
               end
               state_n = S_IDLE;
            end
            if (frame_start) begin
               restart = 1'b1;
               if (!frame_end)
                  drop_inc = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase

      // A new frame starts in the bank chosen after any same-cycle frame_end.
      if (restart) begin
         state_n     = S_ACTIVE;
         x_n         = '0;
         y_n         = '0;
         line_base_n = bank_n ? BANK1_BASE : '0;
      end

      dropped_n = (drop_inc && (dropped_frames != 8'hFF)) ? dropped_frames + 8'd1
                                                          : dropped_frames;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         x              <= '0;
         y              <= '0;
         line_base      <= '0;
         en_q           <= 1'b0;
         wr_en          <= 1'b0;
         wr_addr        <= '0;
         wr_data        <= '0;
         write_bank     <= 1'b0;
         read_bank      <= 1'b1;
         frame_done     <= 1'b0;
         dropped_frames <= '0;
      end else begin
         state          <= state_n;
         x              <= x_n;
         y              <= y_n;
         line_base      <= line_base_n;
         en_q           <= raw_enable;
         wr_en          <= wr_en_n;
         wr_addr        <= wr_addr_n;
         wr_data        <= wr_data_n;
         write_bank     <= bank_n;
         read_bank      <= ~bank_n;
         frame_done     <= done_n;
         dropped_frames <= dropped_n;
      end
   end

endmodule
